stump_sequencer: RTL and testbench
==================================

# stump_sequencer

Instruction sequencer for the Stump core: owns the 2-bit `state` register that drives the control decoder and steps it through FETCH, EXECUTE and MEMORY. It holds a state while memory is not ready and detects memory-wait timeouts. It also provides run/halt/single-step debug control at instruction boundaries and counts retired instructions. It sits between the memory interface and the control decoder, and its outputs gate register and memory commits in the datapath.

## Interface
- `MAX_WAIT`, 15: consecutive not-ready cycles in a memory state before timeout (1..255).
- `RESET_RUN`, 1: 1 = run after reset; 0 = halted after reset.
- `COUNT_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low; one clock, and reset is synchronous and active-low.
- `ir`  in  16  current instruction register contents; only bits [15:13] are used.
- `mem_ready`  in  1  memory completes the access presented this cycle.
- `halt_req`  in  1  request halt at the next instruction boundary.
- `run_req`  in  1  pulse; leave the halted state and free-run.
- `step_req`  in  1  pulse; leave the halted state for exactly one instruction.
- `state`  out  2  FETCH=2'b00, EXECUTE=2'b01, MEMORY=2'b10; registered.
- `core_en`  out  1  the datapath may commit this cycle's decoded actions; combinational.
- `ir_en`  out  1  load IR at this edge; combinational.
- `stall`  out  1  waiting on memory; combinational.
- `instr_done`  out  1  this cycle completes an instruction; combinational.
- `halted`  out  1  core is halted; registered.
- `mem_timeout`  out  1  sticky memory-timeout flag; registered.
- `instr_count`  out  COUNT_W  count of retired instructions; registered; wraps.

## Operation
- Reset (`rst`=0 at an edge) gives:
  - `state`=FETCH, `halted`=~RESET_RUN, `mem_timeout`=0, `instr_count`=0;
  - halt-pending, step flag and wait counter all cleared.
- This applies mid-instruction as well; any partially executed instruction is abandoned.
- Memory states are FETCH and MEMORY. `stall` = ~`halted` & memory state & ~`mem_ready`.
- `core_en` = ~`halted` & ~`stall`.
- Transitions, taken only when `core_en`=1:
  - FETCH → EXECUTE.
  - EXECUTE → MEMORY if `ir[15:13]`==3'b110 (LDST); otherwise → FETCH. ADD..OR and BCC (3'b111) therefore take 2 states.
  - MEMORY → FETCH.
- When `core_en`=0, `state` holds.
- Illegal `state` 2'b11 → FETCH on the next edge, with no commit (`core_en`=0 in that state).
- `ir_en` = `core_en` & (`state`==FETCH).
- `instr_done` = `core_en` & ((EXECUTE & non-LDST) | MEMORY). When set:
  - `instr_count` increments modulo 2^COUNT_W;
  - this is the instruction boundary.
- Halt control:
  - `halt_req`=1 sets halt-pending.
  - At a boundary where halt-pending or the step flag is set: `halted`←1, both flags are cleared, and `state`←FETCH.
  - If `halt_req`=1 while already halted, the core stays halted and halt-pending is not set.
  - `run_req` while halted and `halt_req`=0: `halted`←0 and `mem_timeout`←0.
  - `step_req` while halted and `halt_req`=0: `halted`←0 and the step flag←1. Exactly one instruction then retires, followed by a halt.
  - If `step_req` and `run_req` arrive together, step wins.
  - `run_req` and `step_req` are ignored while running.
- Timeout:
  - The wait counter increments each cycle `stall`=1 and clears whenever `stall`=0 or the state changes.
  - When the counter reaches MAX_WAIT with `stall` still 1: `mem_timeout`←1, `halted`←1, `state`←FETCH. The instruction is abandoned and not counted.
  - `mem_timeout` stays set until reset or an accepted `run_req`; an accepted `step_req` leaves it set.

## Timing
- Zero-wait memory: non-LDST instructions take 2 cycles and LDST takes 3 cycles. Each not-ready cycle adds 1.
- IR is loaded at the edge ending FETCH. From that edge the new `ir` is valid throughout EXECUTE.
- Halt latency: `halted` goes to 1 on the edge ending the cycle that has `instr_done`=1 and halt-pending set. This includes `halt_req` arriving in that same cycle.
- From halted, `run_req` at edge N gives `halted`=0 after N. FETCH then commits in cycle N+1 if `mem_ready`=1.
- Timeout: with `mem_ready` held at 0 from the first cycle of a memory state, `mem_timeout` and `halted` rise after the MAX_WAIT-th stalled cycle.

## Test plan
- Reset mid-MEMORY with `rst`=0 for one edge → `state`=00, `instr_count`=0, `halted`=0 (RESET_RUN=1), `mem_timeout`=0.
- `mem_ready`=1, ADD (ir=16'h0000) then LD (ir=16'hC000):
  - state sequence 00,01,00,01,10,00;
  - `instr_done` pulses in cycles 2 and 5;
  - `instr_count`=2.
- FETCH with `mem_ready`=0 for 3 cycles, MAX_WAIT=15 → `stall`=1 and `core_en`=0 for 3 cycles, `state` holds 00, then proceeds to EXECUTE.
- `halt_req` one-cycle pulse during FETCH of a BCC → the instruction completes, `halted`=1, `state`=00. Then `step_req` → exactly one instruction retires (`instr_count`+1) and `halted` returns to 1.
- `mem_ready` held at 0 in MEMORY with MAX_WAIT=4 → `mem_timeout`=1 and `halted`=1 after 4 stalled cycles, `instr_count` unchanged. Then `run_req` → `mem_timeout`=0 and `halted`=0.
- While halted, `halt_req`=1 and `run_req`=1 together → remains halted. `instr_count` at 2^COUNT_W−1 plus one retire → wraps to 0.

Source files
------------

// File: rtl/stump_sequencer_if.sv
// Sequencer bus: memory handshake, IR opcode, debug requests, and the control/status outputs.
// The slave modport is the sequencer; the master modport is the memory/debug/decoder side.
interface stump_sequencer_if #(
  parameter int unsigned COUNT_W = 16
);
  logic [15:0]        ir;
  logic               mem_ready;
  logic               halt_req;
  logic               run_req;
  logic               step_req;
  logic [1:0]         state;
  logic               core_en;
  logic               ir_en;
  logic               stall;
  logic               instr_done;
  logic               halted;
  logic               mem_timeout;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output ir, mem_ready, halt_req, run_req, step_req,
    input  state, core_en, ir_en, stall, instr_done, halted, mem_timeout, instr_count
  );

  modport slave (
    input  ir, mem_ready, halt_req, run_req, step_req,
    output state, core_en, ir_en, stall, instr_done, halted, mem_timeout, instr_count
  );
endinterface

// File: rtl/stump_sequencer.sv
// Stump FETCH/EXECUTE/MEMORY sequencer with debug halt/run/step, memory-wait timeout and retire counter.
// One state per cycle; holds on mem_ready=0 in memory states, timing out after MAX_WAIT stalled cycles.
module stump_sequencer #(
  parameter int unsigned MAX_WAIT  = 15,
  parameter bit          RESET_RUN = 1'b1,
  parameter int unsigned COUNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  stump_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_MEMORY  = 2'b10,
    S_ILLEGAL = 2'b11
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e             state_q, state_d;
  logic               halted_q, halted_d;
  logic               timeout_q, timeout_d;
  logic               pend_q, pend_d;
  logic               step_q, step_d;
  logic [7:0]         wait_q, wait_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic is_ldst;
  logic mem_state;
  logic stall;
  logic core_en;
  logic instr_done;
  logic ir_unused;

  assign is_ldst   = (bus.ir[15:13] == 3'b110);
  assign ir_unused = ^bus.ir[12:0];
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign stall     = !halted_q && mem_state && !bus.mem_ready;
  // The illegal encoding never commits; it only recovers to FETCH.
  assign core_en   = !halted_q && !stall && (state_q != S_ILLEGAL);
  assign instr_done = core_en &&
                      (((state_q == S_EXECUTE) && !is_ldst) || (state_q == S_MEMORY));

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    pend_d    = pend_q;
    step_d    = step_q;
    count_d   = count_q;
    wait_d    = stall ? (wait_q + 8'd1) : 8'd0;

    if (state_q == S_ILLEGAL) begin
      state_d = S_FETCH;
    end else if (core_en) begin
      case (state_q)
        S_FETCH:   state_d = S_EXECUTE;
        S_EXECUTE: state_d = is_ldst ? S_MEMORY : S_FETCH;
        S_MEMORY:  state_d = S_FETCH;
        default:   state_d = S_FETCH;
      endcase
    end

    if (halted_q) begin
      // Step takes priority over run; a concurrent halt request keeps the core halted.
      if (!bus.halt_req) begin
        if (bus.step_req) begin
          halted_d = 1'b0;
          step_d   = 1'b1;
        end else if (bus.run_req) begin
          halted_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
    end else begin
      if (bus.halt_req) pend_d = 1'b1;
      if (instr_done) begin
        count_d = count_q + COUNT_W'(1);
        if (pend_d || step_q) begin
          halted_d = 1'b1;
          pend_d   = 1'b0;
          step_d   = 1'b0;
          state_d  = S_FETCH;
        end
      end
      if (stall && (wait_q == WAIT_LAST)) begin
        timeout_d = 1'b1;
        halted_d  = 1'b1;
        pend_d    = 1'b0;
        step_d    = 1'b0;
        wait_d    = 8'd0;
        state_d   = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      halted_q  <= !RESET_RUN;
      timeout_q <= 1'b0;
      pend_q    <= 1'b0;
      step_q    <= 1'b0;
      wait_q    <= 8'd0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      pend_q    <= pend_d;
      step_q    <= step_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.core_en     = core_en;
  assign bus.ir_en       = core_en && (state_q == S_FETCH);
  assign bus.stall       = stall;
  assign bus.instr_done  = instr_done;
  assign bus.halted      = halted_q;
  assign bus.mem_timeout = timeout_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_stump_sequencer.sv
// Directed bench for stump_sequencer: instruction timing, memory stalls, halt/step/run, timeout, counter wrap.
module tb_stump_sequencer;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stump_sequencer_if #(.COUNT_W(CW)) sif ();

  stump_sequencer #(
    .MAX_WAIT (4),
    .RESET_RUN(1'b1),
    .COUNT_W  (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst           = 1'b0;
    sif.ir        = 16'h0000;
    sif.mem_ready = 1'b1;
    sif.halt_req  = 1'b0;
    sif.run_req   = 1'b0;
    sif.step_req  = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(sif.state), 0);
    chk("rst_count", 32'(sif.instr_count), 0);
    chk("rst_halted", 32'(sif.halted), 0);
    chk("rst_timeout", 32'(sif.mem_timeout), 0);
    rst = 1'b1; #1;

    // ADD then LD with zero-wait memory
    chk("a1_state", 32'(sif.state), 0);
    chk("a1_ir_en", 32'(sif.ir_en), 1);
    chk("a1_done", 32'(sif.instr_done), 0);
    tick();
    chk("a2_state", 32'(sif.state), 1);
    chk("a2_done", 32'(sif.instr_done), 1);
    tick();
    chk("a3_state", 32'(sif.state), 0);
    chk("a3_count", 32'(sif.instr_count), 1);
    chk("a3_done", 32'(sif.instr_done), 0);
    tick(); sif.ir = 16'hC000; #1;
    chk("a4_state", 32'(sif.state), 1);
    chk("a4_done", 32'(sif.instr_done), 0);
    tick();
    chk("a5_state", 32'(sif.state), 2);
    chk("a5_done", 32'(sif.instr_done), 1);
    tick();
    chk("a6_state", 32'(sif.state), 0);
    chk("a6_count", 32'(sif.instr_count), 2);

    // three not-ready cycles in FETCH, one short of timeout
    sif.mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("b_stall", 32'(sif.stall), 1);
      chk("b_core_en", 32'(sif.core_en), 0);
      chk("b_state", 32'(sif.state), 0);
      tick();
    end
    chk("b_timeout", 32'(sif.mem_timeout), 0);
    sif.mem_ready = 1'b1; sif.ir = 16'h0000; #1;
    chk("b_stall_off", 32'(sif.stall), 0);
    chk("b_core_en_on", 32'(sif.core_en), 1);
    tick();
    chk("b_exec", 32'(sif.state), 1);
    chk("b_done", 32'(sif.instr_done), 1);
    tick();
    chk("b_count", 32'(sif.instr_count), 3);

    // halt pulse during FETCH of a BCC, then single step
    sif.halt_req = 1'b1; #1;
    chk("c_core_en", 32'(sif.core_en), 1);
    tick(); sif.halt_req = 1'b0; sif.ir = 16'hE000; #1;
    chk("c_exec", 32'(sif.state), 1);
    chk("c_not_halted", 32'(sif.halted), 0);
    chk("c_done", 32'(sif.instr_done), 1);
    tick();
    chk("c_halted", 32'(sif.halted), 1);
    chk("c_state", 32'(sif.state), 0);
    chk("c_count", 32'(sif.instr_count), 4);
    chk("c_core_en_off", 32'(sif.core_en), 0);
    chk("c_ir_en_off", 32'(sif.ir_en), 0);
    tick();
    chk("c_hold_halted", 32'(sif.halted), 1);
    chk("c_hold_count", 32'(sif.instr_count), 4);
    sif.step_req = 1'b1; #1;
    tick(); sif.step_req = 1'b0; #1;
    chk("c_step_run", 32'(sif.halted), 0);
    chk("c_step_ir_en", 32'(sif.ir_en), 1);
    tick();
    chk("c_step_exec", 32'(sif.state), 1);
    chk("c_step_done", 32'(sif.instr_done), 1);
    tick();
    chk("c_step_halted", 32'(sif.halted), 1);
    chk("c_step_count", 32'(sif.instr_count), 5);
    chk("c_step_state", 32'(sif.state), 0);
    tick();
    chk("c_step_stays", 32'(sif.instr_count), 5);

    // LDST stalled in MEMORY until timeout (MAX_WAIT=4)
    sif.run_req = 1'b1; #1;
    tick(); sif.run_req = 1'b0; #1;
    chk("d_running", 32'(sif.halted), 0);
    tick(); sif.ir = 16'hC000; #1;
    chk("d_exec", 32'(sif.state), 1);
    chk("d_exec_done", 32'(sif.instr_done), 0);
    tick(); sif.mem_ready = 1'b0; #1;
    chk("d_mem", 32'(sif.state), 2);
    chk("d_stall", 32'(sif.stall), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("d_wait_timeout", 32'(sif.mem_timeout), 0);
      chk("d_wait_halted", 32'(sif.halted), 0);
      chk("d_wait_state", 32'(sif.state), 2);
    end
    tick();
    chk("d_timeout", 32'(sif.mem_timeout), 1);
    chk("d_to_halted", 32'(sif.halted), 1);
    chk("d_to_state", 32'(sif.state), 0);
    chk("d_to_count", 32'(sif.instr_count), 5);
    chk("d_to_stall", 32'(sif.stall), 0);
    sif.mem_ready = 1'b1; sif.ir = 16'h0000; sif.step_req = 1'b1; #1;
    tick(); sif.step_req = 1'b0; #1;
    chk("d_step_run", 32'(sif.halted), 0);
    chk("d_step_keeps_to", 32'(sif.mem_timeout), 1);
    tick();
    chk("d_step_done", 32'(sif.instr_done), 1);
    tick();
    chk("d_step_halted", 32'(sif.halted), 1);
    chk("d_step_count", 32'(sif.instr_count), 6);
    sif.run_req = 1'b1; #1;
    tick(); sif.run_req = 1'b0; #1;
    chk("d_run_halted", 32'(sif.halted), 0);
    chk("d_run_timeout", 32'(sif.mem_timeout), 0);

    // halt+run together while halted, then counter wrap
    sif.halt_req = 1'b1; #1;
    tick(); sif.halt_req = 1'b0; #1;
    chk("e_exec", 32'(sif.state), 1);
    tick();
    chk("e_halted", 32'(sif.halted), 1);
    chk("e_count", 32'(sif.instr_count), 7);
    sif.halt_req = 1'b1; sif.run_req = 1'b1; #1;
    tick(); sif.halt_req = 1'b0; sif.run_req = 1'b0; #1;
    chk("e_both_halted", 32'(sif.halted), 1);
    sif.run_req = 1'b1; #1;
    tick(); sif.run_req = 1'b0; #1;
    chk("e_run", 32'(sif.halted), 0);
    tick(); tick();
    chk("e_no_pending", 32'(sif.halted), 0);
    chk("e_count8", 32'(sif.instr_count), 8);
    chk("e_state", 32'(sif.state), 0);
    for (int i = 0; i < 7; i++) begin
      tick(); tick();
    end
    chk("e_count_max", 32'(sif.instr_count), 15);
    tick(); tick();
    chk("e_wrap", 32'(sif.instr_count), 0);
    tick(); tick();
    chk("e_after_wrap", 32'(sif.instr_count), 1);

    // reset in the middle of a MEMORY cycle
    sif.ir = 16'hC000; #1;
    tick(); tick();
    chk("f_mem", 32'(sif.state), 2);
    rst = 1'b0; #1;
    tick(); rst = 1'b1; #1;
    chk("f_state", 32'(sif.state), 0);
    chk("f_count", 32'(sif.instr_count), 0);
    chk("f_halted", 32'(sif.halted), 0);
    chk("f_timeout", 32'(sif.mem_timeout), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
